// File: rtl/puff_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package    : puff_sched_pkg
// Description: Shared state encoding and default timing constants for the
//              fuel-injection puff scheduler.
// Revision   : 1.0 - initial release
// ============================================================================
package puff_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      RUN   = 2'd2,
      FAULT = 2'd3
   } puff_sched_state_t;

   localparam logic [15:0] PUFF_SCHED_STALL_JF_DEF   = 16'd25000;
   localparam int          PUFF_SCHED_ARM_CYCLES_DEF = 4;

endpackage : puff_sched_pkg
`default_nettype wire

// File: rtl/puff_scheduler_jiffy_watchdog.sv
`default_nettype none
// ============================================================================
// Module     : jiffy_watchdog
// Description: Strobe-driven up-counter with clear and enable that saturates
//              at a programmable limit and flags expiry.
// Revision   : 1.0 - initial release
// ============================================================================
module jiffy_watchdog #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic             i_strobe,
   input  logic [WIDTH-1:0] i_limit,
   output logic             o_expired
);

   logic [WIDTH-1:0] r_count;

   // Clear has priority so a same-cycle clear beats the terminal tick.
   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_count <= '0;
      end else if (i_en && i_strobe && (r_count != i_limit)) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign o_expired = (r_count == i_limit);

endmodule : jiffy_watchdog
`default_nettype wire

// File: rtl/puff_scheduler.sv
`default_nettype none
// ============================================================================
// Module     : puff_scheduler
// Description: Sequences the puff timer: timeout/length config, enable arming,
//              bank alternation, puff counting and stall fault handling.
//              Macro PUFF_SCHED_BANK_ALT_EN enables per-puff bank alternation.
// Revision   : 1.0 - initial release
// ============================================================================
module puff_scheduler
   import puff_sched_pkg::*;
#(
   parameter logic [15:0] STALL_JF   = PUFF_SCHED_STALL_JF_DEF,
   parameter int          ARM_CYCLES = PUFF_SCHED_ARM_CYCLES_DEF
) (
   input  logic        sysclk,
   input  logic        sysreset,
   input  logic        pulse50k,
   input  logic        mcu_run,
   input  logic [15:0] mcu_len_us,
   input  logic        mcu_len_wr,
   input  logic [15:0] mcu_timeout_jf,
   input  logic        mcu_timeout_wr,
   input  logic        puff_event,
   output logic [15:0] puff_len_us,
   output logic [15:0] ign_timeout_len_jf,
   output logic        puff_enable,
   output logic        bank_sel,
   output logic [15:0] puff_count,
   output logic        stall_fault,
   output logic [1:0]  state
);

   localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;

   puff_sched_state_t r_state, w_state_nxt;
   logic              w_enable_nxt, w_fault_nxt;
   logic              r_puff_enable, r_stall_fault;
   logic [ARM_W-1:0]  r_arm_cnt;
   logic              w_arm_done;
   logic              r_timeout_valid;
   logic [15:0]       r_ign_timeout;
   logic [15:0]       r_len_stage, r_puff_len;
   logic              r_len_pending, w_len_commit;
   logic              r_evt_q, r_puff_rise, r_puff_fall;
   logic              w_puff_end;
   logic [15:0]       r_puff_count;
   logic              w_stall_expired;

   assign w_arm_done   = (r_arm_cnt == ARM_W'(ARM_CYCLES - 1));
   assign w_len_commit = r_len_pending && !puff_event;
   assign w_puff_end   = r_puff_fall && (r_state == RUN);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (mcu_run && r_timeout_valid) w_state_nxt = ARM;
         ARM:     if (!mcu_run) w_state_nxt = IDLE;
                  else if (w_arm_done) w_state_nxt = RUN;
         RUN:     if (!mcu_run) w_state_nxt = IDLE;
                  else if (w_stall_expired) w_state_nxt = FAULT;
         FAULT:   if (!mcu_run) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      w_enable_nxt = (w_state_nxt == RUN);
      w_fault_nxt  = (w_state_nxt == FAULT);
   end

   always_ff @(posedge sysclk) begin
      if (sysreset) begin
         r_state       <= IDLE;
         r_puff_enable <= 1'b0;
         r_stall_fault <= 1'b0;
         r_arm_cnt     <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_puff_enable <= w_enable_nxt;
         r_stall_fault <= w_fault_nxt;
         r_arm_cnt     <= (r_state == ARM) ? r_arm_cnt + ARM_W'(1) : '0;
      end
   end

   always_ff @(posedge sysclk) begin
      if (sysreset) begin
         r_timeout_valid <= 1'b0;
         r_ign_timeout   <= 16'hFFFF;
      end else if (mcu_timeout_wr) begin
         r_timeout_valid <= 1'b1;
         r_ign_timeout   <= mcu_timeout_jf;
      end
   end

   // A write coinciding with a commit stays staged so the latest value wins.
   always_ff @(posedge sysclk) begin
      if (sysreset) begin
         r_len_stage   <= '0;
         r_len_pending <= 1'b0;
         r_puff_len    <= '0;
      end else begin
         if (w_len_commit) r_puff_len <= r_len_stage;
         if (mcu_len_wr) begin
            r_len_stage   <= mcu_len_us;
            r_len_pending <= 1'b1;
         end else if (w_len_commit) begin
            r_len_pending <= 1'b0;
         end
      end
   end

   always_ff @(posedge sysclk) begin
      if (sysreset) begin
         r_evt_q      <= 1'b0;
         r_puff_rise  <= 1'b0;
         r_puff_fall  <= 1'b0;
         r_puff_count <= '0;
      end else begin
         r_evt_q     <= puff_event;
         r_puff_rise <= puff_event && !r_evt_q;
         r_puff_fall <= !puff_event && r_evt_q;
         if (w_puff_end) r_puff_count <= r_puff_count + 16'd1;
      end
   end

`ifdef PUFF_SCHED_BANK_ALT_EN
   logic r_bank_sel;

   always_ff @(posedge sysclk) begin
      if (sysreset) begin
         r_bank_sel <= 1'b0;
      end else if (w_puff_end) begin
         r_bank_sel <= ~r_bank_sel;
      end
   end

   assign bank_sel = r_bank_sel;
`else
   assign bank_sel = 1'b0;
`endif

   // Held at zero outside RUN so every entry to RUN starts a fresh count.
   jiffy_watchdog #(
      .WIDTH (16)
   ) u_stall_wdog (
      .clk       (sysclk),
      .rst       (sysreset),
      .i_clr     ((r_state != RUN) || r_puff_rise),
      .i_en      (r_state == RUN),
      .i_strobe  (pulse50k),
      .i_limit   (STALL_JF),
      .o_expired (w_stall_expired)
   );

   assign puff_len_us        = r_puff_len;
   assign ign_timeout_len_jf = r_ign_timeout;
   assign puff_enable        = r_puff_enable;
   assign puff_count         = r_puff_count;
   assign stall_fault        = r_stall_fault;
   assign state              = r_state;

endmodule : puff_scheduler
`default_nettype wire

// File: tb/tb_puff_scheduler.sv
`default_nettype none
// ============================================================================
// Module     : tb_puff_scheduler
// Description: Directed self-checking bench for puff_scheduler.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_puff_scheduler;

   logic        sysclk;
   logic        sysreset;
   logic        pulse50k;
   logic        mcu_run;
   logic [15:0] mcu_len_us;
   logic        mcu_len_wr;
   logic [15:0] mcu_timeout_jf;
   logic        mcu_timeout_wr;
   logic        puff_event;
   logic [15:0] puff_len_us;
   logic [15:0] ign_timeout_len_jf;
   logic        puff_enable;
   logic        bank_sel;
   logic [15:0] puff_count;
   logic        stall_fault;
   logic [1:0]  state;

   int n_cmp = 0;
   int n_err = 0;

   puff_scheduler dut (
      .sysclk             (sysclk),
      .sysreset           (sysreset),
      .pulse50k           (pulse50k),
      .mcu_run            (mcu_run),
      .mcu_len_us         (mcu_len_us),
      .mcu_len_wr         (mcu_len_wr),
      .mcu_timeout_jf     (mcu_timeout_jf),
      .mcu_timeout_wr     (mcu_timeout_wr),
      .puff_event         (puff_event),
      .puff_len_us        (puff_len_us),
      .ign_timeout_len_jf (ign_timeout_len_jf),
      .puff_enable        (puff_enable),
      .bank_sel           (bank_sel),
      .puff_count         (puff_count),
      .stall_fault        (stall_fault),
      .state              (state)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge sysclk);
      #1;
   endtask

   task automatic do_reset();
      sysreset = 1'b1;
      pulse50k = 1'b0; mcu_run = 1'b0; mcu_len_us = '0; mcu_len_wr = 1'b0;
      mcu_timeout_jf = '0; mcu_timeout_wr = 1'b0; puff_event = 1'b0;
      step(); step();
      sysreset = 1'b0;
   endtask

   task automatic do_arm();
      mcu_timeout_jf = 16'd500; mcu_timeout_wr = 1'b1;
      step();
      mcu_timeout_wr = 1'b0; mcu_run = 1'b1;
      repeat (5) step();
   endtask

   function automatic logic exp_bank(input int k);
`ifdef PUFF_SCHED_BANK_ALT_EN
      return 1'(k & 1);
`else
      return 1'b0;
`endif
   endfunction

   task automatic test_reset();
      do_reset();
      n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", state); end
      n_cmp++; if (puff_enable !== 1'b0) begin n_err++; $display("FAIL reset_enable got %b exp 0", puff_enable); end
      n_cmp++; if (bank_sel !== 1'b0) begin n_err++; $display("FAIL reset_bank got %b exp 0", bank_sel); end
      n_cmp++; if (stall_fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got %b exp 0", stall_fault); end
      n_cmp++; if (puff_len_us !== 16'd0) begin n_err++; $display("FAIL reset_len got %0d exp 0", puff_len_us); end
      n_cmp++; if (ign_timeout_len_jf !== 16'hFFFF) begin n_err++; $display("FAIL reset_timeout got %h exp ffff", ign_timeout_len_jf); end
      n_cmp++; if (puff_count !== 16'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", puff_count); end
   endtask

   task automatic test_no_timeout();
      mcu_run = 1'b1;
      for (int i = 0; i < 100; i++) begin
         step();
         n_cmp++;
         if (state !== 2'd0 || puff_enable !== 1'b0) begin
            n_err++; $display("FAIL no_timeout cyc %0d state %0d en %b exp 0/0", i, state, puff_enable);
         end
      end
      mcu_run = 1'b0;
      step();
   endtask

   task automatic test_arm();
      mcu_timeout_jf = 16'd500; mcu_timeout_wr = 1'b1;
      step();
      mcu_timeout_wr = 1'b0;
      n_cmp++; if (ign_timeout_len_jf !== 16'd500) begin n_err++; $display("FAIL arm_timeout got %0d exp 500", ign_timeout_len_jf); end
      n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL arm_idle got %0d exp 0", state); end
      mcu_run = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (state !== 2'd1 || puff_enable !== 1'b0) begin
            n_err++; $display("FAIL arm_hold cyc %0d state %0d en %b exp 1/0", i, state, puff_enable);
         end
         step();
      end
      n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL arm_run_state got %0d exp 2", state); end
      n_cmp++; if (puff_enable !== 1'b1) begin n_err++; $display("FAIL arm_run_enable got %b exp 1", puff_enable); end
   endtask

   task automatic test_len_buffer();
      mcu_len_us = 16'd1234; mcu_len_wr = 1'b1;
      step();
      mcu_len_wr = 1'b0;
      n_cmp++; if (puff_len_us !== 16'd0) begin n_err++; $display("FAIL len_staged got %0d exp 0", puff_len_us); end
      step();
      n_cmp++; if (puff_len_us !== 16'd1234) begin n_err++; $display("FAIL len_commit got %0d exp 1234", puff_len_us); end
      mcu_len_us = 16'd111; mcu_len_wr = 1'b1;
      step();
      mcu_len_us = 16'd222;
      step();
      mcu_len_wr = 1'b0;
      n_cmp++; if (puff_len_us !== 16'd111) begin n_err++; $display("FAIL len_collide_first got %0d exp 111", puff_len_us); end
      step();
      n_cmp++; if (puff_len_us !== 16'd222) begin n_err++; $display("FAIL len_last_wins got %0d exp 222", puff_len_us); end
      puff_event = 1'b1;
      step(); step();
      mcu_len_us = 16'd3000; mcu_len_wr = 1'b1;
      step();
      mcu_len_wr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         n_cmp++; if (puff_len_us !== 16'd222) begin n_err++; $display("FAIL len_held cyc %0d got %0d exp 222", i, puff_len_us); end
      end
      puff_event = 1'b0;
      n_cmp++; if (puff_len_us !== 16'd222) begin n_err++; $display("FAIL len_pre_fall got %0d exp 222", puff_len_us); end
      step();
      n_cmp++; if (puff_len_us !== 16'd3000) begin n_err++; $display("FAIL len_after_fall got %0d exp 3000", puff_len_us); end
      step();
   endtask

   task automatic test_bank_count();
      do_reset();
      do_arm();
      n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL bank_run got %0d exp 2", state); end
      n_cmp++; if (bank_sel !== 1'b0) begin n_err++; $display("FAIL bank_init got %b exp 0", bank_sel); end
      for (int k = 1; k <= 3; k++) begin
         puff_event = 1'b1;
         repeat (3) step();
         puff_event = 1'b0;
         step();
         n_cmp++; if (puff_count !== 16'(k - 1)) begin n_err++; $display("FAIL count_early puff %0d got %0d exp %0d", k, puff_count, k - 1); end
         step();
         n_cmp++; if (puff_count !== 16'(k)) begin n_err++; $display("FAIL count puff %0d got %0d exp %0d", k, puff_count, k); end
         n_cmp++; if (bank_sel !== exp_bank(k)) begin n_err++; $display("FAIL bank puff %0d got %b exp %b", k, bank_sel, exp_bank(k)); end
      end
   endtask

   task automatic test_stall();
      pulse50k = 1'b1;
      repeat (24999) step();
      pulse50k = 1'b0;
      repeat (3) step();
      n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL stall_early got %0d exp 2", state); end
      pulse50k = 1'b1;
      step();
      pulse50k = 1'b0;
      n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL stall_terminal got %0d exp 2", state); end
      step();
      n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL stall_state got %0d exp 3", state); end
      n_cmp++; if (stall_fault !== 1'b1) begin n_err++; $display("FAIL stall_fault got %b exp 1", stall_fault); end
      n_cmp++; if (puff_enable !== 1'b0) begin n_err++; $display("FAIL stall_enable got %b exp 0", puff_enable); end
      mcu_run = 1'b0;
      step();
      n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL stall_exit_state got %0d exp 0", state); end
      n_cmp++; if (stall_fault !== 1'b0) begin n_err++; $display("FAIL stall_exit_fault got %b exp 0", stall_fault); end
   endtask

   task automatic test_abort();
      mcu_run = 1'b1;
      step(); step();
      n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL abort_in_arm got %0d exp 1", state); end
      mcu_run = 1'b0;
      step();
      n_cmp++; if (state !== 2'd0 || puff_enable !== 1'b0) begin n_err++; $display("FAIL abort_arm state %0d en %b exp 0/0", state, puff_enable); end
      mcu_run = 1'b1;
      repeat (5) step();
      n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL abort_rerun got %0d exp 2", state); end
      puff_event = 1'b1;
      step(); step();
      mcu_run = 1'b0;
      step();
      n_cmp++; if (state !== 2'd0 || puff_enable !== 1'b0) begin n_err++; $display("FAIL abort_run state %0d en %b exp 0/0", state, puff_enable); end
      puff_event = 1'b0;
      repeat (3) step();
      n_cmp++; if (puff_count !== 16'd3) begin n_err++; $display("FAIL abort_ignored_puff got %0d exp 3", puff_count); end
   endtask

   task automatic test_reset_mid_puff();
      mcu_run = 1'b1;
      repeat (5) step();
      puff_event = 1'b1;
      step(); step();
      n_cmp++; if (puff_enable !== 1'b1) begin n_err++; $display("FAIL midpuff_enable got %b exp 1", puff_enable); end
      sysreset = 1'b1;
      step();
      n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL rst_state got %0d exp 0", state); end
      n_cmp++; if (puff_enable !== 1'b0) begin n_err++; $display("FAIL rst_enable got %b exp 0", puff_enable); end
      n_cmp++; if (bank_sel !== 1'b0) begin n_err++; $display("FAIL rst_bank got %b exp 0", bank_sel); end
      n_cmp++; if (stall_fault !== 1'b0) begin n_err++; $display("FAIL rst_fault got %b exp 0", stall_fault); end
      n_cmp++; if (puff_len_us !== 16'd0) begin n_err++; $display("FAIL rst_len got %0d exp 0", puff_len_us); end
      n_cmp++; if (ign_timeout_len_jf !== 16'hFFFF) begin n_err++; $display("FAIL rst_timeout got %h exp ffff", ign_timeout_len_jf); end
      n_cmp++; if (puff_count !== 16'd0) begin n_err++; $display("FAIL rst_count got %0d exp 0", puff_count); end
      sysreset = 1'b0; puff_event = 1'b0;
      repeat (3) step();
      n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL rst_timeout_valid state %0d exp 0", state); end
      mcu_run = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_no_timeout();
      test_arm();
      test_len_buffer();
      test_bank_count();
      test_stall();
      test_abort();
      test_reset_mid_puff();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_puff_scheduler
`default_nettype wire

// File: doc/puff_scheduler.md
# puff_scheduler

Controller that sequences the fuel-injection puff timer. It owns the timer's configuration inputs (puff length, ignition timeout) and generates the required `puff_enable` arm sequence. It alternates injector banks per puff, counts puffs, and drops the timer into a safe off state when ignition pulses stop. It sits between the MCU register interface and the puff timer peripheral.

## Interface
Parameters:
- `STALL_JF`, default 16'd25000: jiffies (pulse50k ticks) with no puff start before a stall fault; 25000 = 0.5 s.
- `ARM_CYCLES`, default 4: sysclk cycles `puff_enable` is held low in ARM after the timeout value is presented.

Ports:
- `sysclk`  in  1  single clock for the block.
- `sysreset`  in  1  reset, synchronous and active-high.
- `pulse50k`  in  1  one-cycle strobe at 50 kHz (jiffy).
- `mcu_run`  in  1  MCU run request, level.
- `mcu_len_us`  in  16  new puff length in µs, staged.
- `mcu_len_wr`  in  1  one-cycle write strobe for `mcu_len_us`.
- `mcu_timeout_jf`  in  16  ignition timeout in jiffies.
- `mcu_timeout_wr`  in  1  one-cycle write strobe for `mcu_timeout_jf`.
- `puff_event`  in  1  from the timer; high while the injector is open.
- `puff_len_us`  out  16  to the timer.
- `ign_timeout_len_jf`  out  16  to the timer.
- `puff_enable`  out  1  to the timer.
- `bank_sel`  out  1  injector bank for the current/next puff.
- `puff_count`  out  16  completed puffs.
- `stall_fault`  out  1  sticky stall indication.
- `state`  out  2  FSM state, for the MCU/LEDs.

## Operation
- FSM states:
  - IDLE=0: `puff_enable`=0.
    - Go to ARM when `mcu_run` is 1 and `timeout_valid` is 1.
    - `timeout_valid` is set by any `mcu_timeout_wr` and cleared only by reset.
  - ARM=1: `puff_enable`=0 for `ARM_CYCLES` cycles, then go to RUN. This guarantees the timeout is presented before the enable rising edge.
  - RUN=2: `puff_enable`=1. Go to FAULT when the stall counter reaches `STALL_JF`.
  - FAULT=3: `puff_enable`=0, `stall_fault`=1. Leave only through IDLE, when `mcu_run` is 0.
- `mcu_run`=0 in ARM or RUN forces IDLE on the next edge. The ARM counter and stall counter clear.
- `ign_timeout_len_jf` loads from `mcu_timeout_jf` on `mcu_timeout_wr` in any state.
- Puff length is double-buffered:
  - `mcu_len_wr` captures the value into a staging register and sets `len_pending`.
  - The staged value is copied to `puff_len_us` on the first cycle where `puff_event` is sampled 0 and `len_pending` is 1. `len_pending` then clears.
  - Consequence: `puff_len_us` never changes while `puff_event` is high.
  - A write in the same cycle as a commit: the new value stays staged and `len_pending` stays 1. Last write wins.
- Puff end (registered falling edge of `puff_event`):
  - `puff_count` increments, wrapping 0xFFFF→0.
  - `bank_sel` toggles.
  - Puff ends are counted in RUN only. An open puff finishing after leaving RUN is ignored.
- Stall counter (16-bit):
  - Increments on `pulse50k` in RUN.
  - Clears on a registered rising edge of `puff_event` and on entry to RUN.
  - Saturates at `STALL_JF`.
- `stall_fault` clears when FAULT→IDLE.

## Timing
- Reset values:
  - state IDLE.
  - `puff_enable`=0, `bank_sel`=0, `stall_fault`=0.
  - `puff_len_us`=0, `ign_timeout_len_jf`=0xFFFF, `puff_count`=0.
  - `timeout_valid`=0, `len_pending`=0.
- All outputs are registered.
- `mcu_timeout_wr` → `ign_timeout_len_jf` valid on the next edge (1 cycle).
- Length commit latency: 2 cycles after the write if `puff_event` is low (stage, then commit).
- `puff_event` edge detect uses one register. Bank toggle and count increment are visible 2 cycles after the `puff_event` fall at the input.
- IDLE→ARM: 1 cycle. ARM→RUN: exactly `ARM_CYCLES` cycles in ARM. `puff_enable` rises on the cycle state=RUN.
- FAULT entry: the cycle after the counter reaches `STALL_JF`. A puff rise in the same cycle as the terminal tick wins: the counter clears and there is no fault.
- Reset mid-puff: everything returns to reset values immediately, and `puff_enable` drops.

## Configuration
- `PUFF_SCHED_BANK_ALT_EN`
  - Defined: `bank_sel` alternates per puff as described.
  - Undefined: `bank_sel` is a constant 0 and the toggle logic is removed. `puff_count` behaviour is unchanged.

## Structure
- Package `puff_sched_pkg`:
  - enum `puff_sched_state_t` (IDLE, ARM, RUN, FAULT, 2-bit encodings above).
  - Default constants `PUFF_SCHED_STALL_JF_DEF` and `PUFF_SCHED_ARM_CYCLES_DEF`.
- One sub-module, `jiffy_watchdog`: a counter with clear, enable and strobe inputs that saturates at a limit and flags expiry. It implements the stall counter.

## Test plan
- Arm sequence:
  - Stimulus: reset; `mcu_timeout_wr` with 16'd500; `mcu_run`=1.
  - Expect: `ign_timeout_len_jf`=500 before `puff_enable` rises; `puff_enable` low for exactly 4 cycles in ARM, then high; state=2.
- No timeout written:
  - Stimulus: `mcu_run`=1 with no `mcu_timeout_wr` for 100 cycles.
  - Expect: state stays 0; `puff_enable`=0.
- Length double-buffer:
  - Stimulus: in RUN, hold `puff_event`=1; write `mcu_len_us`=3000.
  - Expect: `puff_len_us` unchanged until 1 cycle after `puff_event` falls, then 3000.
- Bank and count:
  - Stimulus: 3 puff pulses in RUN.
  - Expect: `puff_count`=3; `bank_sel` sequence 0→1→0→1. With the macro undefined, `bank_sel` stays 0.
- Stall:
  - Stimulus: RUN with no `puff_event`; 25000 `pulse50k` strobes.
  - Expect: state=3, `stall_fault`=1, `puff_enable`=0.
  - Then drop `mcu_run`: state=0 and `stall_fault`=0 next cycle.
- Abort:
  - Stimulus: drop `mcu_run` mid-ARM; separately, assert `sysreset` mid-puff.
  - Expect: IDLE next cycle, `puff_enable`=0. After reset, all outputs at reset values.
